// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: default word size, register-file depth,
// FSM state encoding and the position of the read/write flag in the address byte.
package spi_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned NUM_REGS   = 8;
  // Bit of the address byte that selects write (1) or read (0).
  localparam int unsigned RW_BIT     = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAddr = 2'b01,
    StData = 2'b10
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: pclk_i (clock), prst_i (sync active-low reset), d_i (async in), q_o (synced out).
module spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic pclk_i,
  input  logic prst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with a small register file, oversampled on pclk_i.
// Each frame is an address byte (MSB = write flag, low bits = register index)
// followed by a data byte; several frames may be sent under one chip select.
// Ports: pclk_i/prst_i clock and sync active-low reset; sclk_i/mosi_i/cs_n_i SPI inputs;
// miso_o read data; wr_en_o/wr_addr_o/wr_data_o completed-write strobe;
// frame_err_o aborted-frame strobe; busy_o chip select active;
// rd_addr_i/rd_data_o combinational local read port.
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = spi_pkg::DATA_WIDTH,
  parameter int unsigned NUM_REGS   = spi_pkg::NUM_REGS
) (
  input  logic                        pclk_i,
  input  logic                        prst_i,
  input  logic                        sclk_i,
  input  logic                        mosi_i,
  input  logic                        cs_n_i,
  output logic                        miso_o,
  output logic                        wr_en_o,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]       wr_data_o,
  output logic                        frame_err_o,
  output logic                        busy_o,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]       rd_data_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  logic sclk_s, mosi_s, cs_n_s;
  logic sclk_q, cs_n_q;
  logic sclk_rise, sclk_fall, cs_fall, last_bit;

  spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .pclk_i(pclk_i), .prst_i(prst_i), .d_i(sclk_i), .q_o(sclk_s)
  );
  spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .pclk_i(pclk_i), .prst_i(prst_i), .d_i(mosi_i), .q_o(mosi_s)
  );
  spi_sync #(.RESET_VAL(1'b1)) u_sync_cs_n (
    .pclk_i(pclk_i), .prst_i(prst_i), .d_i(cs_n_i), .q_o(cs_n_s)
  );

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sin_q, sin_d, sin_next;
  logic [DATA_WIDTH-1:0] sout_q, sout_d;
  logic [IDX_W-1:0]      addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic                  miso_q, miso_d;
  logic                  wr_en_q, wr_en_d;
  logic [IDX_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  // The cs_n synchronizer resets to 1 and would fake a falling edge if cs_n is
  // still low when reset releases; only accept a fall once cs_n has really been
  // seen high after the synchronizer pipeline has flushed.
  logic [1:0]            flush_q;
  logic                  armed_q;

  // sclk edges are qualified by chip select so they are ignored while deselected.
  assign sclk_rise = sclk_s & ~sclk_q & ~cs_n_s;
  assign sclk_fall = ~sclk_s & sclk_q & ~cs_n_s;
  assign cs_fall   = cs_n_q & ~cs_n_s;
  assign last_bit  = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign sin_next  = {sin_q[DATA_WIDTH-2:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sin_d     = sin_q;
    sout_d    = sout_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    miso_d    = miso_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (armed_q && cs_fall) state_d = StAddr;
      end
      StAddr: begin
        if (cs_n_s) begin
          // Deselect between frames is a clean end of burst.
          state_d = StIdle;
          err_d   = (cnt_q != '0);
          cnt_d   = '0;
        end else if (sclk_rise) begin
          sin_d = sin_next;
          cnt_d = cnt_q + 1'b1;
          if (last_bit) begin
            cnt_d   = '0;
            state_d = StData;
            addr_d  = sin_next[IDX_W-1:0];
            rw_d    = sin_next[RW_BIT];
            if (!sin_next[RW_BIT]) sout_d = regs_q[sin_next[IDX_W-1:0]];
          end
        end
      end
      StData: begin
        if (cs_n_s) begin
          // Address received but data byte incomplete: always an abort.
          state_d = StIdle;
          err_d   = 1'b1;
          cnt_d   = '0;
          miso_d  = 1'b0;
        end else begin
          if (sclk_fall && !rw_q) begin
            miso_d = sout_q[DATA_WIDTH-1];
            sout_d = {sout_q[DATA_WIDTH-2:0], 1'b0};
          end
          if (sclk_rise) begin
            sin_d = sin_next;
            cnt_d = cnt_q + 1'b1;
            if (last_bit) begin
              cnt_d   = '0;
              state_d = StAddr;
              miso_d  = 1'b0;
              if (rw_q) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = sin_next;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sin_q     <= '0;
      sout_q    <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      miso_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      flush_q   <= '0;
      armed_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sin_q     <= sin_d;
      sout_q    <= sout_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      miso_q    <= miso_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      sclk_q    <= sclk_s;
      cs_n_q    <= cs_n_s;
      flush_q   <= {flush_q[0], 1'b1};
      armed_q   <= armed_q | (flush_q[1] & cs_n_s);
      // Commit in the strobe cycle so the read port shows it the cycle after.
      if (wr_en_q) regs_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign miso_o      = miso_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_err_o = err_q;
  assign busy_o      = ~cs_n_s;
  assign rd_data_o   = regs_q[rd_addr_i];

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

  logic       pclk_i = 1'b0;
  logic       prst_i, sclk_i, mosi_i, cs_n_i;
  logic       miso_o, wr_en_o, frame_err_o, busy_o;
  logic [2:0] wr_addr_o, rd_addr_i;
  logic [7:0] wr_data_o, rd_data_o;

  spi_target u_dut (
    .pclk_i(pclk_i), .prst_i(prst_i), .sclk_i(sclk_i), .mosi_i(mosi_i), .cs_n_i(cs_n_i),
    .miso_o(miso_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .frame_err_o(frame_err_o), .busy_o(busy_o), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
  );

  always #5 pclk_i = ~pclk_i;

  int n_checks = 0;
  int n_fail = 0;
  int half = 4;  // pclk cycles per sclk half period
  int wr_pulses = 0;
  int err_pulses = 0;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t        exp_q[$];
  logic [7:0] model [8];

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge pclk_i) begin
    wr_t e;
    if (wr_en_o) begin
      wr_pulses++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %02h, required no write",
                 wr_addr_o, wr_data_o);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr_o !== e.a || wr_data_o !== e.d) begin
          n_fail++;
          $display("FAIL write_strobe: got addr %0d data %02h, required addr %0d data %02h",
                   wr_addr_o, wr_data_o, e.a, e.d);
        end
      end
    end
    if (frame_err_o) err_pulses++;
  end

  task automatic wait_pclk(input int n);
    repeat (n) @(negedge pclk_i);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi_i = tx[7-i];
      wait_pclk(half);
      sclk_i = 1'b1;
      rx = {rx[6:0], miso_o};
      wait_pclk(half);
      sclk_i = 1'b0;
    end
  endtask

  task automatic push_write(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a[2:0], d});
    model[a[2:0]] = d;
  endtask

  task automatic spi_txn(input logic [7:0] a, input logic [7:0] d, output logic [7:0] rx_d);
    logic [7:0] rx_a;
    spi_bits(a, 8, rx_a);
    if (a[7]) push_write(a, d);
    spi_bits(d, 8, rx_d);
  endtask

  task automatic cs_low();
    cs_n_i = 1'b0;
    wait_pclk(2 * half);
  endtask

  task automatic cs_high();
    wait_pclk(half);
    cs_n_i = 1'b1;
    wait_pclk(10);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      wait_pclk(1);
      k++;
    end
  endtask

  task automatic test_reset();
    prst_i = 1'b0; sclk_i = 1'b0; mosi_i = 1'b0; cs_n_i = 1'b1; rd_addr_i = 3'd0;
    wait_pclk(4);
    n_checks++;
    if ({miso_o, wr_en_o, wr_addr_o, wr_data_o, frame_err_o, busy_o} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %04h, required 0000",
               {miso_o, wr_en_o, wr_addr_o, wr_data_o, frame_err_o, busy_o});
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr_i = 3'(i);
      model[i] = 8'h00;
      #1;
      n_checks++;
      if (rd_data_o !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %02h, required 00", i, rd_data_o);
      end
    end
    prst_i = 1'b1;
    wait_pclk(5);
  endtask

  task automatic test_write();
    int w0 = wr_pulses;
    logic [7:0] rx;
    cs_low();
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL busy_active: got %b, required 1", busy_o);
    end
    spi_txn(8'hD3, 8'h46, rx);
    cs_high();
    drain();
    n_checks++;
    if (exp_q.size() != 0 || wr_pulses - w0 != 1) begin
      n_fail++;
      $display("FAIL write_count: got %0d pulses, required 1", wr_pulses - w0);
    end
    wait_pclk(3);
    n_checks++;
    if (wr_addr_o !== 3'd3 || wr_data_o !== 8'h46) begin
      n_fail++;
      $display("FAIL write_hold: got %0d/%02h, required 3/46", wr_addr_o, wr_data_o);
    end
    rd_addr_i = 3'd3;
    #1;
    n_checks++;
    if (rd_data_o !== 8'h46) begin
      n_fail++; $display("FAIL write_readback: got %02h, required 46", rd_data_o);
    end
    n_checks++;
    if (err_pulses != 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write_idle: got err %0d busy %b, required 0 0", err_pulses, busy_o);
    end
  endtask

  task automatic test_burst();
    int w0 = wr_pulses;
    int e0 = err_pulses;
    logic [7:0] rx;
    cs_low();
    spi_txn(8'h80, 8'h11, rx);
    spi_txn(8'h81, 8'h22, rx);
    spi_txn(8'h82, 8'h33, rx);
    cs_high();
    drain();
    n_checks++;
    if (wr_pulses - w0 != 3 || err_pulses != e0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL burst_count: got %0d writes %0d errs, required 3 0",
               wr_pulses - w0, err_pulses - e0);
    end
    for (int i = 0; i < 3; i++) begin
      rd_addr_i = 3'(i);
      #1;
      n_checks++;
      if (rd_data_o !== model[i]) begin
        n_fail++;
        $display("FAIL burst_reg%0d: got %02h, required %02h", i, rd_data_o, model[i]);
      end
    end
  endtask

  task automatic test_read();
    int w0 = wr_pulses;
    int e0 = err_pulses;
    logic [7:0] rx_a, rx_d;
    cs_low();
    spi_bits(8'h03, 8, rx_a);
    spi_bits(8'h00, 8, rx_d);
    cs_high();
    n_checks++;
    if (rx_a !== 8'h00) begin
      n_fail++; $display("FAIL read_miso_addr: got %02h, required 00", rx_a);
    end
    n_checks++;
    if (rx_d !== model[3]) begin
      n_fail++; $display("FAIL read_data: got %02h, required %02h", rx_d, model[3]);
    end
    n_checks++;
    if (wr_pulses != w0 || err_pulses != e0 || miso_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_side: got %0d writes %0d errs miso %b, required 0 0 0",
               wr_pulses - w0, err_pulses - e0, miso_o);
    end
  endtask

  task automatic test_abort();
    int w0 = wr_pulses;
    int e0 = err_pulses;
    logic [7:0] rx;
    cs_low();
    spi_bits(8'h85, 8, rx);
    spi_bits(8'hAA, 5, rx);
    cs_high();
    n_checks++;
    if (err_pulses - e0 != 1 || wr_pulses != w0) begin
      n_fail++;
      $display("FAIL abort_pulse: got %0d errs %0d writes, required 1 0",
               err_pulses - e0, wr_pulses - w0);
    end
    rd_addr_i = 3'd5;
    #1;
    n_checks++;
    if (rd_data_o !== model[5]) begin
      n_fail++; $display("FAIL abort_reg5: got %02h, required %02h", rd_data_o, model[5]);
    end
    cs_low();
    spi_txn(8'h85, 8'h3C, rx);
    cs_high();
    drain();
    rd_addr_i = 3'd5;
    #1;
    n_checks++;
    if (rd_data_o !== 8'h3C || err_pulses - e0 != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_recover: got %02h errs %0d, required 3c 1", rd_data_o,
               err_pulses - e0);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_pulses;
    int e0 = err_pulses;
    logic [7:0] rx;
    cs_low();
    spi_bits(8'h87, 8, rx);
    spi_bits(8'h5A, 2, rx);
    prst_i = 1'b0;
    wait_pclk(3);
    n_checks++;
    if ({miso_o, wr_en_o, wr_addr_o, wr_data_o, frame_err_o, busy_o} !== 15'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %04h, required 0000",
               {miso_o, wr_en_o, wr_addr_o, wr_data_o, frame_err_o, busy_o});
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr_i = 3'(i);
      model[i] = 8'h00;
      #1;
      n_checks++;
      if (rd_data_o !== 8'h00) begin
        n_fail++; $display("FAIL midreset_reg%0d: got %02h, required 00", i, rd_data_o);
      end
    end
    prst_i = 1'b1;
    wait_pclk(4);
    // cs_n still low after reset: the clocks below belong to no frame.
    spi_bits(8'hFF, 8, rx);
    wait_pclk(8);
    n_checks++;
    if (wr_pulses != w0 || err_pulses != e0) begin
      n_fail++;
      $display("FAIL midreset_stale: got %0d writes %0d errs, required 0 0",
               wr_pulses - w0, err_pulses - e0);
    end
    cs_high();
    cs_low();
    spi_txn(8'h87, 8'h5A, rx);
    cs_high();
    drain();
    rd_addr_i = 3'd7;
    #1;
    n_checks++;
    if (rd_data_o !== 8'h5A || err_pulses != e0 || wr_pulses - w0 != 1) begin
      n_fail++;
      $display("FAIL midreset_write: got %02h writes %0d errs %0d, required 5a 1 0",
               rd_data_o, wr_pulses - w0, err_pulses - e0);
    end
  endtask

  task automatic test_idle_sclk_fast();
    int w0 = wr_pulses;
    int e0 = err_pulses;
    logic [7:0] rx;
    for (int i = 0; i < 16; i++) begin
      mosi_i = 1'($urandom_range(0, 1));
      sclk_i = ~sclk_i;
      wait_pclk(2);
    end
    sclk_i = 1'b0;
    wait_pclk(6);
    n_checks++;
    if (wr_pulses != w0 || err_pulses != e0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_sclk: got %0d writes %0d errs busy %b, required 0 0 0",
               wr_pulses - w0, err_pulses - e0, busy_o);
    end
    half = 2;
    cs_low();
    spi_txn(8'h84, 8'hC3, rx);
    cs_high();
    drain();
    half = 4;
    rd_addr_i = 3'd4;
    #1;
    n_checks++;
    if (rd_data_o !== 8'hC3 || wr_pulses - w0 != 1 || err_pulses != e0) begin
      n_fail++;
      $display("FAIL fast_write: got %02h writes %0d errs %0d, required c3 1 0",
               rd_data_o, wr_pulses - w0, err_pulses - e0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst();
    test_read();
    test_abort();
    test_reset_mid();
    test_idle_sclk_fast();
    wait_pclk(5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL pending_writes: got %0d, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, required finish before 2 ms");
    $fatal(1, "timeout");
  end

endmodule
